push_button_unit: RTL and testbench

PUSH_BUTTON_UNIT -- requirements
Module: push_button_unit

---
 rtl/pb_pkg.sv | 16 +
 rtl/pb_debounce_cell.sv | 123 ++++++++++++
 rtl/push_button_unit.sv | 46 ++++
 tb/tb_push_button_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
// Shared definitions for the push-button unit: button count, auto-repeat timing
// and the repeat FSM state type (used only when PB_AUTO_REPEAT_EN is defined).
package pb_pkg;

  localparam int NUM_BUTTONS        = 4;
  localparam int REPEAT_DELAY_TICKS = 500;
  localparam int REPEAT_RATE_TICKS  = 100;
  localparam int REPEAT_CNT_W       = $clog2(REPEAT_DELAY_TICKS);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } repeat_state_t;

endpackage

// File: rtl/pb_debounce_cell.sv
// One debounced button: synchronizer, sample history, accepted level and press event.
// Optional auto-repeat FSM is built only when PB_AUTO_REPEAT_EN is defined.
module pb_debounce_cell
  import pb_pkg::*;
#(
  parameter int NUM_SAMPLES = 8
) (
  input  logic clock_50,
  input  logic resetn,
  input  logic tick,
  input  logic button_n,
  output logic pressed,
  output logic event_pulse
);

  logic                   sync_meta;
  logic                   sync_out;
  logic [NUM_SAMPLES-1:0] history;
  logic [NUM_SAMPLES-1:0] history_next;
  logic                   pressed_next;
  logic                   rise;
  logic                   event_next;

  // The level only changes once the whole window agrees; mixed windows hold it.
  always_comb begin
    history_next = history;
    pressed_next = pressed;
    if (tick) begin
      history_next = {history[NUM_SAMPLES-2:0], ~sync_out};
      if (&history_next) begin
        pressed_next = 1'b1;
      end else if (history_next == '0) begin
        pressed_next = 1'b0;
      end
    end
  end

  assign rise = pressed_next & ~pressed;

`ifdef PB_AUTO_REPEAT_EN
  repeat_state_t           rpt_state;
  repeat_state_t           rpt_state_next;
  logic [REPEAT_CNT_W-1:0] rpt_cnt;
  logic [REPEAT_CNT_W-1:0] rpt_cnt_next;
  logic                    rpt_fire;

  // Counting starts on the press edge, so repeats stay aligned to sample ticks.
  always_comb begin
    rpt_state_next = rpt_state;
    rpt_cnt_next   = rpt_cnt;
    rpt_fire       = 1'b0;
    if (!pressed_next) begin
      rpt_state_next = RPT_IDLE;
      rpt_cnt_next   = '0;
    end else begin
      case (rpt_state)
        RPT_IDLE: begin
          if (rise) begin
            rpt_state_next = RPT_DELAY;
            rpt_cnt_next   = '0;
          end
        end
        RPT_DELAY: begin
          if (tick) begin
            if (rpt_cnt == REPEAT_CNT_W'(REPEAT_DELAY_TICKS - 1)) begin
              rpt_fire       = 1'b1;
              rpt_state_next = RPT_REPEAT;
              rpt_cnt_next   = '0;
            end else begin
              rpt_cnt_next = rpt_cnt + 1'b1;
            end
          end
        end
        RPT_REPEAT: begin
          if (tick) begin
            if (rpt_cnt == REPEAT_CNT_W'(REPEAT_RATE_TICKS - 1)) begin
              rpt_fire     = 1'b1;
              rpt_cnt_next = '0;
            end else begin
              rpt_cnt_next = rpt_cnt + 1'b1;
            end
          end
        end
        default: begin
          rpt_state_next = RPT_IDLE;
          rpt_cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      rpt_state <= RPT_IDLE;
      rpt_cnt   <= '0;
    end else begin
      rpt_state <= rpt_state_next;
      rpt_cnt   <= rpt_cnt_next;
    end
  end

  assign event_next = rise | rpt_fire;
`else
  assign event_next = rise;
`endif

  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      sync_meta   <= 1'b1;
      sync_out    <= 1'b1;
      history     <= '0;
      pressed     <= 1'b0;
      event_pulse <= 1'b0;
    end else begin
      sync_meta   <= button_n;
      sync_out    <= sync_meta;
      history     <= history_next;
      pressed     <= pressed_next;
      event_pulse <= event_next;
    end
  end

endmodule

// File: rtl/push_button_unit.sv
// Four-button debouncer with a shared sample-tick divider.
// Define PB_AUTO_REPEAT_EN to add held-button auto-repeat events.
module push_button_unit
  import pb_pkg::*;
#(
  parameter int CLK_DIV     = 50000,
  parameter int NUM_SAMPLES = 8
) (
  input  logic                   clock_50,
  input  logic                   resetn,
  input  logic [NUM_BUTTONS-1:0] push_button_n,
  output logic [NUM_BUTTONS-1:0] pb_pressed,
  output logic [NUM_BUTTONS-1:0] pb_event,
  output logic                   sample_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] tick_cnt;

  assign sample_tick = (tick_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clock_50 or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (sample_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_cell
    pb_debounce_cell #(
      .NUM_SAMPLES(NUM_SAMPLES)
    ) u_cell (
      .clock_50   (clock_50),
      .resetn     (resetn),
      .tick       (sample_tick),
      .button_n   (push_button_n[i]),
      .pressed    (pb_pressed[i]),
      .event_pulse(pb_event[i])
    );
  end

endmodule

// File: tb/tb_push_button_unit.sv
// Directed bench for push_button_unit (CLK_DIV=10, NUM_SAMPLES=4) with an event scoreboard.
// Auto-repeat expectations follow PB_AUTO_REPEAT_EN.
module tb_push_button_unit;

  logic       clock_50 = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] push_button_n = 4'hF;
  logic [3:0] pb_pressed;
  logic [3:0] pb_event;
  logic       sample_tick;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];
  int         obs_cyc_q[$];
  int         got_stamps[$];

  push_button_unit #(
    .CLK_DIV    (10),
    .NUM_SAMPLES(4)
  ) dut (
    .clock_50     (clock_50),
    .resetn       (resetn),
    .push_button_n(push_button_n),
    .pb_pressed   (pb_pressed),
    .pb_event     (pb_event),
    .sample_tick  (sample_tick)
  );

  always #10 clock_50 = ~clock_50;

  always @(posedge clock_50) cyc <= cyc + 1;

  // Every nonzero event word the DUT produces, stamped with the edge count.
  always @(negedge clock_50) begin
    if (pb_event !== 4'b0000) begin
      obs_q.push_back(pb_event);
      obs_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock_50);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] buttons_n, input logic [3:0] expected_event);
    push_button_n = buttons_n;
    if (expected_event != 4'b0000) exp_q.push_back(expected_event);
  endtask

  task automatic drainScoreboard(input string tag);
    logic [3:0] exp_v;
    got_stamps.delete();
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        checkOutput({tag, " missing"}, 32'h0, {28'h0, exp_v});
      end else begin
        got_stamps.push_back(obs_cyc_q.pop_front());
        checkOutput(tag, {28'h0, obs_q.pop_front()}, {28'h0, exp_v});
      end
    end
    checkOutput({tag, " extra events"}, obs_q.size(), 0);
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  initial begin
    int start_cyc;
    int rel_cyc;
    int lat;

    // Reset state
    wait_cycles(3);
    checkOutput("reset pb_pressed", pb_pressed, 4'b0000);
    checkOutput("reset pb_event", pb_event, 4'b0000);
    checkOutput("reset sample_tick", sample_tick, 1'b0);

    // Tick cadence: count equals k mod 10 after k edges, tick when it reaches 9
    resetn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock_50);
      checkOutput($sformatf("tick k=%0d", k), sample_tick, ((k % 10) == 9) ? 1 : 0);
    end

    // Clean press on button 0
    start_cyc = cyc;
    applyStimulus(4'b1110, 4'b0001);
    wait_cycles(60);
    checkOutput("clean pressed", pb_pressed, 4'b0001);
    drainScoreboard("clean event");
    if (got_stamps.size() > 0)
      checkOutput("clean latency within 53", (got_stamps[0] - start_cyc) <= 53, 1);
    applyStimulus(4'b1111, 4'b0000);
    wait_cycles(60);
    checkOutput("clean release pressed", pb_pressed, 4'b0000);
    drainScoreboard("clean release");

    // Bounce on button 1: never stable for 4 ticks
    for (int i = 0; i < 13; i++) begin
      applyStimulus(push_button_n ^ 4'b0010, 4'b0000);
      wait_cycles(15);
    end
    checkOutput("bounce no events", obs_q.size(), 0);
    checkOutput("bounce pressed held", pb_pressed, 4'b0000);
    applyStimulus(4'b1101, 4'b0010);
    wait_cycles(60);
    checkOutput("bounce final pressed", pb_pressed, 4'b0010);
    drainScoreboard("bounce event");
    applyStimulus(4'b1111, 4'b0000);
    wait_cycles(60);
    drainScoreboard("bounce release");

    // Simultaneous presses on buttons 1 and 3
    applyStimulus(4'b0101, 4'b1010);
    wait_cycles(60);
    checkOutput("simul pressed", pb_pressed, 4'b1010);
    drainScoreboard("simul event");
    applyStimulus(4'b1111, 4'b0000);
    wait_cycles(60);
    checkOutput("simul release pressed", pb_pressed, 4'b0000);
    drainScoreboard("simul release");

    // Reset mid-debounce while button 2 is held
    applyStimulus(4'b1011, 4'b0100);
    wait_cycles(20);
    resetn = 1'b0;
    #1;
    checkOutput("midreset pb_pressed", pb_pressed, 4'b0000);
    checkOutput("midreset pb_event", pb_event, 4'b0000);
    checkOutput("midreset sample_tick", sample_tick, 1'b0);
    wait_cycles(3);
    checkOutput("midreset late pb_pressed", pb_pressed, 4'b0000);
    resetn = 1'b1;
    rel_cyc = cyc;
    wait_cycles(60);
    checkOutput("postreset pressed", pb_pressed, 4'b0100);
    drainScoreboard("postreset event");
    if (got_stamps.size() > 0) begin
      lat = got_stamps[0] - rel_cyc;
      checkOutput("postreset latency 40..53", (lat >= 40) && (lat <= 53), 1);
    end
    applyStimulus(4'b1111, 4'b0000);
    wait_cycles(60);
    drainScoreboard("postreset release");

    // Long hold on button 3 (800 ticks)
    applyStimulus(4'b0111, 4'b1000);
`ifdef PB_AUTO_REPEAT_EN
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b1000);
`endif
    wait_cycles(8000);
    applyStimulus(4'b1111, 4'b0000);
    wait_cycles(100);
    checkOutput("hold release pressed", pb_pressed, 4'b0000);
    drainScoreboard("hold events");
`ifdef PB_AUTO_REPEAT_EN
    if (got_stamps.size() == 4) begin
      checkOutput("repeat first gap", got_stamps[1] - got_stamps[0], 5000);
      checkOutput("repeat second gap", got_stamps[2] - got_stamps[1], 1000);
      checkOutput("repeat third gap", got_stamps[3] - got_stamps[2], 1000);
    end
`endif
    wait_cycles(200);
    drainScoreboard("after hold quiet");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
